// File: rtl/weight_bias_loader.sv
`default_nettype none
// ============================================================================
//  Module   : weight_bias_loader
//  Purpose  : Write-side sequencer that turns a valid/ready word stream into
//             weight/bias strobes for one layer of ELM neurons. Each neuron
//             receives NUM_WEIGHT weights followed by one bias.
//  Revision : 1.0  initial release
// ============================================================================
module weight_bias_loader #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_WEIGHT   = 128,
  parameter int NUM_NEURONS  = 64,
  parameter int FIRST_NEURON = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   layer_sel,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic [DATA_WIDTH-1:0]   weightValue,
  output logic                    weightValid,
  output logic [DATA_WIDTH-1:0]   biasValue,
  output logic                    biasValid,
  output logic [2*DATA_WIDTH:0]   config_layer_num,
  output logic [2*DATA_WIDTH:0]   config_neuron_num,
  output logic                    busy,
  output logic                    done,
  output logic                    err_last
);

  localparam int CFG_W = 2*DATA_WIDTH + 1;
  localparam int W_CW  = (NUM_WEIGHT  > 1) ? $clog2(NUM_WEIGHT)  : 1;
  localparam int N_CW  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam logic [W_CW-1:0] W_LAST = W_CW'(NUM_WEIGHT - 1);
  localparam logic [N_CW-1:0] N_LAST = N_CW'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WEIGHT = 2'd1,
    S_BIAS   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [W_CW-1:0]         w_cnt_q, w_cnt_d;
  logic [N_CW-1:0]         n_cnt_q, n_cnt_d;
  logic [DATA_WIDTH-1:0]   layer_q, layer_d;
  logic                    err_q, err_d;

  logic                    weight_valid_q;
  logic                    bias_valid_q;
  logic [DATA_WIDTH-1:0]   weight_value_q;
  logic [DATA_WIDTH-1:0]   bias_value_q;
  logic [CFG_W-1:0]        cfg_layer_q;
  logic [CFG_W-1:0]        cfg_neuron_q;

  logic                    accept;
  logic                    is_final;
  logic [CFG_W-1:0]        neuron_num;

  // Ready depends on state only: the neurons never push back.
  assign s_ready    = (state_q == S_WEIGHT) || (state_q == S_BIAS);
  assign accept     = s_valid && s_ready;
  assign is_final   = (state_q == S_BIAS) && (n_cnt_q == N_LAST);
  assign neuron_num = CFG_W'(FIRST_NEURON) + {{(CFG_W-N_CW){1'b0}}, n_cnt_q};

  // State, counters, latched layer and sticky s_last error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_cnt_q <= '0;
      n_cnt_q <= '0;
      layer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_cnt_q <= w_cnt_d;
      n_cnt_q <= n_cnt_d;
      layer_q <= layer_d;
      err_q   <= err_d;
    end
  end

  // Next-state sequencing: NUM_WEIGHT weights then one bias per neuron.
  always_comb begin
    state_d = state_q;
    w_cnt_d = w_cnt_q;
    n_cnt_d = n_cnt_q;
    layer_d = layer_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WEIGHT;
          layer_d = layer_sel;
          w_cnt_d = '0;
          n_cnt_d = '0;
          err_d   = 1'b0;
        end
      end
      S_WEIGHT: begin
        if (accept) begin
          if (w_cnt_q == W_LAST) begin
            state_d = S_BIAS;
          end else begin
            w_cnt_d = w_cnt_q + 1'b1;
          end
        end
      end
      S_BIAS: begin
        if (accept) begin
          if (n_cnt_q == N_LAST) begin
            state_d = S_DONE;
          end else begin
            n_cnt_d = n_cnt_q + 1'b1;
            w_cnt_d = '0;
            state_d = S_WEIGHT;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // s_last must appear on the final bias and nowhere else; the word is still delivered.
    if (accept && (s_last != is_final)) begin
      err_d = 1'b1;
    end
  end

  // Output registers: strobes, data and target numbers one cycle after accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weight_valid_q <= 1'b0;
      bias_valid_q   <= 1'b0;
      weight_value_q <= '0;
      bias_value_q   <= '0;
      cfg_layer_q    <= '0;
      cfg_neuron_q   <= '0;
    end else begin
      weight_valid_q <= accept && (state_q == S_WEIGHT);
      bias_valid_q   <= accept && (state_q == S_BIAS);
      if (accept && (state_q == S_WEIGHT)) begin
        weight_value_q <= s_data;
      end
      if (accept && (state_q == S_BIAS)) begin
        bias_value_q <= s_data;
      end
      // Target numbers only move together with a strobe, so they are stable between strobes.
      if (accept) begin
        cfg_layer_q  <= {{(CFG_W-DATA_WIDTH){1'b0}}, layer_q};
        cfg_neuron_q <= neuron_num;
      end
    end
  end

  assign weightValid       = weight_valid_q;
  assign biasValid         = bias_valid_q;
  assign weightValue       = weight_value_q;
  assign biasValue         = bias_value_q;
  assign config_layer_num  = cfg_layer_q;
  assign config_neuron_num = cfg_neuron_q;
  assign busy              = (state_q != S_IDLE);
  assign done              = (state_q == S_DONE);
  assign err_last          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_weight_bias_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_weight_bias_loader
//  Purpose  : Self-checking bench for weight_bias_loader using randomized
//             word streams and a word-index based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_weight_bias_loader;

  localparam int DW    = 16;
  localparam int NW    = 4;
  localparam int NN    = 2;
  localparam int FN    = 0;
  localparam int TOTAL = NN * (NW + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance
  logic          start = 1'b0, s_valid = 1'b0, s_last = 1'b0;
  logic [DW-1:0] layer_sel = '0, s_data = '0;
  logic          s_ready, weightValid, biasValid, busy, done, err_last;
  logic [DW-1:0] weightValue, biasValue;
  logic [2*DW:0] config_layer_num, config_neuron_num;

  // single-neuron instance with an offset neuron number
  logic          b_start = 1'b0, b_valid = 1'b0, b_last = 1'b0;
  logic [DW-1:0] b_layer = '0, b_data = '0;
  logic          b_ready, b_wv, b_bv, b_busy, b_done, b_err;
  logic [DW-1:0] b_wval, b_bval;
  logic [2*DW:0] b_cfg_layer, b_cfg_neuron;

  weight_bias_loader #(.DATA_WIDTH(DW), .NUM_WEIGHT(NW), .NUM_NEURONS(NN), .FIRST_NEURON(FN)) dut (
    .clk(clk), .rst(rst), .start(start), .layer_sel(layer_sel), .s_data(s_data),
    .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready), .weightValue(weightValue),
    .weightValid(weightValid), .biasValue(biasValue), .biasValid(biasValid),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .busy(busy), .done(done), .err_last(err_last)
  );

  weight_bias_loader #(.DATA_WIDTH(DW), .NUM_WEIGHT(NW), .NUM_NEURONS(1), .FIRST_NEURON(35)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .layer_sel(b_layer), .s_data(b_data),
    .s_valid(b_valid), .s_last(b_last), .s_ready(b_ready), .weightValue(b_wval),
    .weightValid(b_wv), .biasValue(b_bval), .biasValid(b_bv),
    .config_layer_num(b_cfg_layer), .config_neuron_num(b_cfg_neuron),
    .busy(b_busy), .done(b_done), .err_last(b_err)
  );

  typedef struct packed {
    logic          wv;
    logic          bv;
    logic [DW-1:0] wval;
    logic [DW-1:0] bval;
    logic [2*DW:0] neuron;
    logic [2*DW:0] layer;
    logic          done;
    logic          busy;
    logic          ready;
    logic          err;
  } snap_t;

  int checks = 0;
  int errors = 0;

  // per-cycle stimulus record (index 0 is the start cycle) and observations
  logic          st_v[$];
  logic          st_last[$];
  logic [DW-1:0] st_d[$];
  snap_t         obs_q[$];
  snap_t         exp_q[$];

  // reference model's view of the held output values
  logic [DW-1:0] m_wval = '0, m_bval = '0;
  logic [2*DW:0] m_neuron = '0, m_layer = '0;
  logic          m_err = 1'b0;

  function automatic snap_t take_snap();
    snap_t s;
    s.wv = weightValid;   s.bv = biasValid;
    s.wval = weightValue; s.bval = biasValue;
    s.neuron = config_neuron_num; s.layer = config_layer_num;
    s.done = done; s.busy = busy; s.ready = s_ready; s.err = err_last;
    return s;
  endfunction

  // Drives one layer load. gap_mode toggles s_valid; bad_idx flips s_last on
  // that accepted-word index; mid_idx pulses start alongside that word.
  task automatic drive_load(input logic [DW-1:0] layer, input int gap_mode,
                            input int bad_idx, input int mid_idx);
    int acc = 0;
    int c   = 0;
    logic v;
    st_v.delete(); st_last.delete(); st_d.delete(); obs_q.delete();
    start = 1'b1; layer_sel = layer; s_valid = 1'b0; s_last = 1'b0; s_data = DW'($urandom);
    st_v.push_back(1'b0); st_last.push_back(1'b0); st_d.push_back(s_data);
    @(posedge clk); #1; obs_q.push_back(take_snap());
    while (acc < TOTAL + 2) begin
      v = (acc < TOTAL) ? ((gap_mode != 0) ? (c % 2 == 0) : 1'b1) : 1'b0;
      c++;
      s_valid   = v;
      s_data    = DW'($urandom);
      layer_sel = DW'($urandom);
      s_last    = v ? ((acc == TOTAL-1) ^ (acc == bad_idx)) : 1'($urandom);
      start     = (v && acc == mid_idx);
      st_v.push_back(v); st_last.push_back(s_last); st_d.push_back(s_data);
      @(posedge clk); #1; obs_q.push_back(take_snap());
      if (v || acc >= TOTAL) acc++;
    end
    start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
  endtask

  // Expected outputs from word position: word k goes to neuron k/(NW+1) and is
  // the bias when k%(NW+1)==NW; the loader is ready until TOTAL words are taken.
  task automatic build_expected(input logic [DW-1:0] layer);
    int acc = 0;
    snap_t e;
    exp_q.delete();
    m_err = 1'b0;
    e = '0;
    e.wval = m_wval; e.bval = m_bval; e.neuron = m_neuron; e.layer = m_layer;
    e.busy = 1'b1; e.ready = 1'b1;
    exp_q.push_back(e);
    for (int i = 1; i < st_v.size(); i++) begin
      e = '0;
      if (acc < TOTAL) begin
        if (st_v[i]) begin
          if (acc % (NW+1) < NW) begin e.wv = 1'b1; m_wval = st_d[i]; end
          else begin e.bv = 1'b1; m_bval = st_d[i]; end
          m_neuron = (2*DW+1)'(FN + acc / (NW+1));
          m_layer  = (2*DW+1)'(layer);
          if (st_last[i] != (acc == TOTAL-1)) m_err = 1'b1;
          e.done = (acc == TOTAL-1);
          acc++;
        end
        e.busy  = 1'b1;
        e.ready = (acc < TOTAL);
      end
      e.wval = m_wval; e.bval = m_bval; e.neuron = m_neuron; e.layer = m_layer;
      e.err = m_err;
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    s_valid = 1'b1;
    #1;
    checks++;
    if (take_snap() !== snap_t'(0)) begin
      errors++; $display("FAIL reset_hold got %h exp %h", take_snap(), snap_t'(0));
    end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (take_snap() !== snap_t'(0)) begin
      errors++; $display("FAIL idle_no_start got %h exp %h", take_snap(), snap_t'(0));
    end
    s_valid = 1'b0;
    m_wval = '0; m_bval = '0; m_neuron = '0; m_layer = '0; m_err = 1'b0;
  endtask

  task automatic test_basic();
    drive_load(16'd1, 0, -1, -1);
    build_expected(16'd1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL basic_len got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_gaps();
    logic [DW-1:0] l = DW'($urandom);
    drive_load(l, 1, -1, -1);
    build_expected(l);
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL gaps cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_slast();
    // early s_last on word 3, then a clean load, then a missing final s_last
    int bad[3] = '{2, -1, TOTAL-1};
    for (int t = 0; t < 3; t++) begin
      logic [DW-1:0] l = DW'($urandom);
      drive_load(l, t % 2, bad[t], -1);
      build_expected(l);
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL slast%0d cyc %0d got %h exp %h", t, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_start_mid();
    logic [DW-1:0] l = DW'($urandom);
    drive_load(l, 0, -1, 5);
    build_expected(l);
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL start_mid cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1; layer_sel = 16'd7;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      s_valid = 1'b1; s_data = DW'($urandom); s_last = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    checks++;
    if (weightValid !== 1'b1 || config_neuron_num !== 33'd1) begin
      errors++; $display("FAIL pre_rst_word6 got wv=%b n=%0d exp wv=1 n=1", weightValid, config_neuron_num);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (take_snap() !== snap_t'(0)) begin
      errors++; $display("FAIL async_rst got %h exp %h", take_snap(), snap_t'(0));
    end
    @(posedge clk); #1; rst = 1'b0;
    m_wval = '0; m_bval = '0; m_neuron = '0; m_layer = '0; m_err = 1'b0;
    drive_load(16'd3, 0, -1, -1);
    build_expected(16'd3);
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL reload cyc %0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_first_neuron();
    logic [DW-1:0] d;
    b_start = 1'b1; b_layer = 16'd2;
    @(posedge clk); #1; b_start = 1'b0;
    for (int k = 0; k < NW + 1; k++) begin
      d = DW'($urandom);
      b_valid = 1'b1; b_data = d; b_last = (k == NW);
      @(posedge clk); #1;
      checks++;
      if (b_wv !== (k < NW) || b_bv !== (k == NW) || b_cfg_neuron !== 33'd35 ||
          b_cfg_layer !== 33'd2 || ((k < NW) ? b_wval : b_bval) !== d) begin
        errors++;
        $display("FAIL first_neuron word %0d got wv=%b bv=%b n=%0d l=%0d wval=%h bval=%h exp n=35 l=2 data=%h",
                 k, b_wv, b_bv, b_cfg_neuron, b_cfg_layer, b_wval, b_bval, d);
      end
    end
    b_valid = 1'b0; b_last = 1'b0;
    checks++;
    if (b_done !== 1'b1 || b_err !== 1'b0 || b_ready !== 1'b0) begin
      errors++; $display("FAIL first_neuron_done got done=%b err=%b rdy=%b exp 1 0 0", b_done, b_err, b_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (b_busy !== 1'b0 || b_done !== 1'b0) begin
      errors++; $display("FAIL first_neuron_idle got busy=%b done=%b exp 0 0", b_busy, b_done);
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 3; t++) begin
      logic [DW-1:0] l = DW'($urandom);
      drive_load(l, int'($urandom_range(0, 1)), -1, -1);
      build_expected(l);
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL b2b%0d cyc %0d got %h exp %h", t, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_slast();
    test_start_mid();
    test_async_reset();
    test_first_neuron();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
